// File: rtl/nnrv_mem_arb_if.sv
// ============================================================================
// Module      : nnrv_mem_arb_if
// Description : Requester (IF, LS), memory-macro and status signals of the
//               unified-memory arbiter, bundled with arbiter/client modports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface nnrv_mem_arb_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic            i_if_req;
   logic [AW-1:0]   i_if_addr;
   logic            o_if_gnt;
   logic            o_if_rvalid;
   logic [DW-1:0]   o_if_rdata;

   logic            i_ls_req;
   logic            i_ls_we;
   logic [AW-1:0]   i_ls_addr;
   logic [DW-1:0]   i_ls_wdata;
   logic [DW/8-1:0] i_ls_wstrb;
   logic            o_ls_gnt;
   logic            o_ls_rvalid;
   logic [DW-1:0]   o_ls_rdata;

   logic            o_mem_en;
   logic            o_mem_we;
   logic [AW-1:0]   o_mem_addr;
   logic [DW-1:0]   o_mem_wdata;
   logic [DW/8-1:0] o_mem_wstrb;
   logic [DW-1:0]   i_mem_rdata;

   logic            o_busy;

   modport slave (
      input  i_if_req, i_if_addr,
      output o_if_gnt, o_if_rvalid, o_if_rdata,
      input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_wstrb,
      output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
      output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
      input  i_mem_rdata,
      output o_busy
   );

   modport master (
      output i_if_req, i_if_addr,
      input  o_if_gnt, o_if_rvalid, o_if_rdata,
      output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_wstrb,
      input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
      input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb,
      output i_mem_rdata,
      input  o_busy
   );
endinterface

`default_nettype wire

// File: rtl/nnrv_mem_arb.sv
// ============================================================================
// Module      : nnrv_mem_arb
// Description : Single-transaction arbiter between instruction fetch and the
//               load/store unit for one single-port memory. Optional macro
//               NNRV_ARB_RR_EN turns tie-breaking into round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nnrv_mem_arb #(
   parameter int AW     = 12,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   nnrv_mem_arb_if.slave bus
);

   localparam int         SW       = DW / 8;
   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t          state_q;
   logic            owner_ls_q;
   logic            we_q;
   logic [1:0]      cnt_q;
   logic            if_gnt_q;
   logic            ls_gnt_q;
   logic            if_rvalid_q;
   logic            ls_rvalid_q;
   logic [DW-1:0]   if_rdata_q;
   logic [DW-1:0]   ls_rdata_q;
   logic            mem_en_q;
   logic            mem_we_q;
   logic [AW-1:0]   mem_addr_q;
   logic [DW-1:0]   mem_wdata_q;
   logic [SW-1:0]   mem_wstrb_q;
   logic            pick_ls_d;

`ifdef NNRV_ARB_RR_EN
   logic last_ls_q;

   // On a tie the requester that did not own the previous transaction wins.
   always_comb pick_ls_d = bus.i_ls_req & (~bus.i_if_req | ~last_ls_q);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_ls_q <= 1'b1;
      end else if (state_q == S_ISSUE) begin
         last_ls_q <= owner_ls_q;
      end
   end
`else
   always_comb pick_ls_d = bus.i_ls_req;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         owner_ls_q  <= 1'b0;
         we_q        <= 1'b0;
         cnt_q       <= 2'd0;
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
      end else begin
         if_gnt_q    <= 1'b0;
         ls_gnt_q    <= 1'b0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // The memory command registers double as the transaction latch.
               if (bus.i_if_req | bus.i_ls_req) begin
                  owner_ls_q  <= pick_ls_d;
                  we_q        <= pick_ls_d & bus.i_ls_we;
                  if_gnt_q    <= ~pick_ls_d;
                  ls_gnt_q    <= pick_ls_d;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= pick_ls_d & bus.i_ls_we;
                  mem_addr_q  <= pick_ls_d ? bus.i_ls_addr : bus.i_if_addr;
                  mem_wdata_q <= pick_ls_d ? bus.i_ls_wdata : '0;
                  mem_wstrb_q <= pick_ls_d ? bus.i_ls_wstrb : '0;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               mem_en_q <= 1'b0;
               mem_we_q <= 1'b0;
               cnt_q    <= CNT_INIT;
               state_q  <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == 2'd0) begin
                  if (owner_ls_q) begin
                     ls_rvalid_q <= 1'b1;
                     ls_rdata_q  <= we_q ? '0 : bus.i_mem_rdata;
                  end else begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= bus.i_mem_rdata;
                  end
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_if_gnt    = if_gnt_q;
   assign bus.o_if_rvalid = if_rvalid_q;
   assign bus.o_if_rdata  = if_rdata_q;
   assign bus.o_ls_gnt    = ls_gnt_q;
   assign bus.o_ls_rvalid = ls_rvalid_q;
   assign bus.o_ls_rdata  = ls_rdata_q;
   assign bus.o_mem_en    = mem_en_q;
   assign bus.o_mem_we    = mem_we_q;
   assign bus.o_mem_addr  = mem_addr_q;
   assign bus.o_mem_wdata = mem_wdata_q;
   assign bus.o_mem_wstrb = mem_wstrb_q;
   assign bus.o_busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_nnrv_mem_arb.sv
// ============================================================================
// Module      : tb_nnrv_mem_arb
// Description : Bench for nnrv_mem_arb at RD_LAT 1 and 4: directed scenarios,
//               random traffic, and a transaction-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nnrv_mem_arb;

   localparam int AW = 12;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'hDEAD_BEEF;
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_lat
      localparam int L = (k == 0) ? 1 : 4;

      logic rst  = 1'b1;
      logic done = 1'b0;

      nnrv_mem_arb_if #(.AW(AW), .DW(DW)) bus ();

      nnrv_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(L)) u_dut (
         .i_clk (clk),
         .i_rst (rst),
         .bus   (bus.slave)
      );

      // Memory macro: read data appears L cycles after the command cycle.
      logic [DW-1:0] mem  [0:4095];
      logic [DW-1:0] pipe [0:3];
      logic          mem_ready = 1'b0;

      always @(posedge clk) begin
         if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
         end else if (bus.o_mem_en && bus.o_mem_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.o_mem_wstrb[b]) mem[bus.o_mem_addr][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
         end
         pipe[0] <= (mem_ready && bus.o_mem_en && !bus.o_mem_we) ? mem[bus.o_mem_addr] : $urandom;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign bus.i_mem_rdata = pipe[L-1];

      // Reference model: each accepted transaction is a timeline
      // (sample c -> gnt c+1 -> rvalid c+2+L -> next sample c+L+3).
      logic [DW-1:0] refm [0:4095];

      initial begin : p_model
         int            gnt_c, rv_c, busy_lo, busy_hi, free_at, c;
         bit            t_ls, t_we, last_ls, pick;
         logic [AW-1:0] t_addr;
         logic [DW-1:0] t_wdata, t_rdata, e_if_rd, e_ls_rd;
         logic [3:0]    t_wstrb;
         logic [6:0]    e_ctl, a_ctl;
         gnt_c = -1; rv_c = -1; busy_lo = 1; busy_hi = 0; free_at = 0;
         t_ls = 1'b0; t_we = 1'b0; last_ls = 1'b1; pick = 1'b0;
         t_addr = '0; t_wdata = '0; t_rdata = '0; t_wstrb = '0;
         e_if_rd = '0; e_ls_rd = '0;
         for (int i = 0; i < 4096; i++) refm[i] = init_word(i);
         forever begin
            @(negedge clk);
            c = cyc;
            if (c == rv_c) begin
               if (t_ls) e_ls_rd = t_rdata;
               else      e_if_rd = t_rdata;
            end
            e_ctl = {c == gnt_c && !t_ls, c == gnt_c && t_ls, c == rv_c && !t_ls, c == rv_c && t_ls,
                     c == gnt_c, c == gnt_c && t_we, c >= busy_lo && c <= busy_hi};
            a_ctl = {bus.o_if_gnt, bus.o_ls_gnt, bus.o_if_rvalid, bus.o_ls_rvalid,
                     bus.o_mem_en, bus.o_mem_we, bus.o_busy};
            chk($sformatf("L%0d_ctl{ifg,lsg,ifv,lsv,en,we,busy}@%0d", L, c), 64'(a_ctl), 64'(e_ctl));
            chk($sformatf("L%0d_if_rdata@%0d", L, c), 64'(bus.o_if_rdata), 64'(e_if_rd));
            chk($sformatf("L%0d_ls_rdata@%0d", L, c), 64'(bus.o_ls_rdata), 64'(e_ls_rd));
            if (c == gnt_c) begin
               chk($sformatf("L%0d_mem_addr@%0d", L, c), 64'(bus.o_mem_addr), 64'(t_addr));
               if (t_we) begin
                  chk($sformatf("L%0d_mem_wdata@%0d", L, c), 64'(bus.o_mem_wdata), 64'(t_wdata));
                  chk($sformatf("L%0d_mem_wstrb@%0d", L, c), 64'(bus.o_mem_wstrb), 64'(t_wstrb));
               end
            end
            if (rst) begin
               if (gnt_c > c) gnt_c = -1;
               if (rv_c > c) rv_c = -1;
               if (busy_hi > c) busy_hi = c;
               free_at = c + 1;
               e_if_rd = '0;
               e_ls_rd = '0;
               last_ls = 1'b1;
            end else if (c >= free_at && (bus.i_if_req || bus.i_ls_req)) begin
`ifdef NNRV_ARB_RR_EN
               pick = bus.i_ls_req && (!bus.i_if_req || !last_ls);
`else
               pick = bus.i_ls_req;
`endif
               t_ls    = pick;
               t_we    = pick && bus.i_ls_we;
               t_addr  = pick ? bus.i_ls_addr : bus.i_if_addr;
               t_wdata = bus.i_ls_wdata;
               t_wstrb = bus.i_ls_wstrb;
               t_rdata = t_we ? '0 : refm[t_addr];
               if (t_we)
                  for (int b = 0; b < 4; b++)
                     if (t_wstrb[b]) refm[t_addr][8*b +: 8] = t_wdata[8*b +: 8];
               last_ls = pick;
               gnt_c   = c + 1;
               busy_lo = c + 1;
               busy_hi = c + 2 + L;
               rv_c    = c + 2 + L;
               free_at = c + L + 3;
            end
         end
      end

      initial begin : p_stim
         int guard, ng, nrv, if_left;
         int order [0:3];
         int gcyc  [0:7];
         int e_ord [0:2];
`ifdef NNRV_ARB_RR_EN
         e_ord = '{0, 1, 0};
`else
         e_ord = '{1, 0, 0};
`endif
         order = '{9, 9, 9, 9};
         rst = 1'b1;
         bus.i_if_req = 1'b0; bus.i_if_addr = '0;
         bus.i_ls_req = 1'b0; bus.i_ls_we = 1'b0; bus.i_ls_addr = '0;
         bus.i_ls_wdata = '0; bus.i_ls_wstrb = '0;
         repeat (3) @(posedge clk);
         #1 rst = 1'b0;

         // IF read of a preloaded word
         bus.i_if_req = 1'b1; bus.i_if_addr = 12'h010;
         guard = 0;
         do begin @(posedge clk); #1; guard++; end while (!bus.o_if_gnt && guard < 20);
         chk($sformatf("L%0d_t1_gnt_lat", L), 64'(guard), 64'd1);
         chk($sformatf("L%0d_t1_mem_addr", L), 64'(bus.o_mem_addr), 64'h010);
         bus.i_if_req = 1'b0;
         guard = 0;
         do begin @(posedge clk); #1; guard++; end while (!bus.o_if_rvalid && guard < 20);
         chk($sformatf("L%0d_t1_rv_lat", L), 64'(guard), 64'(L + 1));
         chk($sformatf("L%0d_t1_rdata", L), 64'(bus.o_if_rdata), 64'hDEAD_BEEF);
         @(posedge clk); #1;

         // LS full-word write
         bus.i_ls_req = 1'b1; bus.i_ls_we = 1'b1; bus.i_ls_addr = 12'h020;
         bus.i_ls_wdata = 32'h1234_5678; bus.i_ls_wstrb = 4'hF;
         guard = 0;
         do begin @(posedge clk); #1; guard++; end while (!bus.o_ls_gnt && guard < 20);
         chk($sformatf("L%0d_t2_gnt_lat", L), 64'(guard), 64'd1);
         chk($sformatf("L%0d_t2_en_we", L), 64'({bus.o_mem_en, bus.o_mem_we}), 64'b11);
         chk($sformatf("L%0d_t2_wdata", L), 64'(bus.o_mem_wdata), 64'h1234_5678);
         bus.i_ls_req = 1'b0; bus.i_ls_we = 1'b0;
         guard = 0;
         do begin @(posedge clk); #1; guard++; end while (!bus.o_ls_rvalid && guard < 20);
         chk($sformatf("L%0d_t2_rv_lat", L), 64'(guard), 64'(L + 1));
         chk($sformatf("L%0d_t2_ls_rdata", L), 64'(bus.o_ls_rdata), 64'd0);
         chk($sformatf("L%0d_t2_if_rvalid", L), 64'(bus.o_if_rvalid), 64'd0);
         @(posedge clk); #1;

         // Simultaneous requests: IF wants two reads, LS one
         bus.i_if_req = 1'b1; bus.i_if_addr = 12'h100;
         bus.i_ls_req = 1'b1; bus.i_ls_addr = 12'h030;
         if_left = 2; ng = 0; guard = 0;
         while (ng < 3 && guard < 100) begin
            @(posedge clk); #1; guard++;
            if (bus.o_if_gnt && ng < 4) begin
               order[ng] = 0; ng++; if_left--;
               if (if_left == 0) bus.i_if_req = 1'b0;
               else              bus.i_if_addr = 12'h101;
            end
            if (bus.o_ls_gnt && ng < 4) begin
               order[ng] = 1; ng++; bus.i_ls_req = 1'b0;
            end
         end
         bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
         chk($sformatf("L%0d_t3_ngrants", L), 64'(ng), 64'd3);
         for (int i = 0; i < 3; i++)
            chk($sformatf("L%0d_t3_order%0d(0=IF,1=LS)", L, i), 64'(order[i]), 64'(e_ord[i]));
         guard = 0;
         while (bus.o_busy && guard < 50) begin @(posedge clk); #1; guard++; end

         // Reset while waiting on memory drops the transaction
         bus.i_if_req = 1'b1; bus.i_if_addr = 12'h055;
         guard = 0;
         do begin @(posedge clk); #1; guard++; end while (!bus.o_if_gnt && guard < 20);
         bus.i_if_req = 1'b0;
         @(posedge clk); #1;
         chk($sformatf("L%0d_t5_busy_in_wait", L), 64'(bus.o_busy), 64'd1);
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         chk($sformatf("L%0d_t5_rst_ctl", L), 64'({bus.o_if_gnt, bus.o_ls_gnt, bus.o_if_rvalid,
             bus.o_ls_rvalid, bus.o_mem_en, bus.o_mem_we, bus.o_busy}), 64'd0);
         chk($sformatf("L%0d_t5_rst_if_rdata", L), 64'(bus.o_if_rdata), 64'd0);
         chk($sformatf("L%0d_t5_rst_mem_addr", L), 64'(bus.o_mem_addr), 64'd0);
         nrv = 0;
         repeat (L + 3) begin
            @(posedge clk); #1;
            if (bus.o_if_rvalid || bus.o_ls_rvalid) nrv++;
         end
         chk($sformatf("L%0d_t5_no_rvalid", L), 64'(nrv), 64'd0);
         bus.i_if_req = 1'b1; bus.i_if_addr = 12'h056;
         guard = 0;
         do begin @(posedge clk); #1; guard++; end while (!bus.o_if_gnt && guard < 20);
         chk($sformatf("L%0d_t5_regrant_lat", L), 64'(guard), 64'd1);
         bus.i_if_req = 1'b0;
         guard = 0;
         while (bus.o_busy && guard < 50) begin @(posedge clk); #1; guard++; end

         // Streaming IF reads of 0x000..0x007
         bus.i_if_addr = '0; bus.i_if_req = 1'b1;
         ng = 0; guard = 0;
         while (ng < 8 && guard < 200) begin
            @(posedge clk); #1; guard++;
            if (bus.o_if_gnt) begin
               gcyc[ng] = cyc; ng++;
               if (ng == 8) bus.i_if_req = 1'b0;
               else         bus.i_if_addr = AW'(ng);
            end
         end
         bus.i_if_req = 1'b0;
         chk($sformatf("L%0d_t6_ngrants", L), 64'(ng), 64'd8);
         for (int i = 1; i < ng; i++)
            chk($sformatf("L%0d_t6_gap%0d", L, i), 64'(gcyc[i] - gcyc[i-1]), 64'(L + 3));
         guard = 0;
         while (bus.o_busy && guard < 50) begin @(posedge clk); #1; guard++; end

         // Random traffic with occasional resets
         for (int s = 0; s < 400; s++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 79) == 0);
            if (!bus.i_if_req || bus.o_if_gnt) begin
               bus.i_if_req  = ($urandom_range(0, 2) != 0);
               bus.i_if_addr = AW'($urandom_range(0, 63));
            end
            if (!bus.i_ls_req || bus.o_ls_gnt) begin
               bus.i_ls_req   = ($urandom_range(0, 2) != 0);
               bus.i_ls_we    = 1'($urandom_range(0, 1));
               bus.i_ls_addr  = AW'($urandom_range(0, 63));
               bus.i_ls_wdata = $urandom;
               bus.i_ls_wstrb = 4'($urandom);
            end
         end
         @(posedge clk); #1;
         rst = 1'b0; bus.i_if_req = 1'b0; bus.i_ls_req = 1'b0;
         guard = 0;
         while (bus.o_busy && guard < 50) begin @(posedge clk); #1; guard++; end
         chk($sformatf("L%0d_drain_idle", L), 64'(bus.o_busy), 64'd0);
         repeat (3) @(posedge clk);
         done = 1'b1;
      end
   end

   initial begin : p_main
      int t;
      t = 0;
      while (!(g_lat[0].done && g_lat[1].done) && t < 20000) begin
         @(posedge clk);
         t++;
      end
      chk("run_complete", 64'(g_lat[0].done && g_lat[1].done), 64'd1);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nnrv_mem_arb.md
Name: nnrv_mem_arb

Overview:
- Arbitrates one single-port unified memory between two requesters in nnrv_top: instruction fetch (IF) and load/store unit (LS).
- Accepts one transaction at a time.
- Sequences the memory command and waits the fixed memory read latency.
- Returns read data, or a write acknowledge, to the requester that owns the transaction.
- Sits between nnrv_if / LSU and the memory macro.

Parameters:
AW, 12, word-address width
DW, 32, data width
RD_LAT, 1, memory read latency in cycles from o_mem_en to i_mem_rdata valid; legal range 1..4

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_if_req  in  1  IF read request; held until o_if_gnt
i_if_addr  in  AW  IF word address
o_if_gnt  out  1  one-cycle accept pulse
o_if_rvalid  out  1  one-cycle read-data-valid pulse
o_if_rdata  out  DW  read data
i_ls_req  in  1  LS request; held until o_ls_gnt
i_ls_we  in  1  1 = write, 0 = read
i_ls_addr  in  AW  LS word address
i_ls_wdata  in  DW  write data
i_ls_wstrb  in  DW/8  byte write strobes
o_ls_gnt  out  1  one-cycle accept pulse
o_ls_rvalid  out  1  read-data or write-ack pulse
o_ls_rdata  out  DW  read data; 0 for write ack
o_mem_en  out  1  memory command strobe
o_mem_we  out  1  memory write enable
o_mem_addr  out  AW  memory address
o_mem_wdata  out  DW  memory write data
o_mem_wstrb  out  DW/8  memory byte strobes
i_mem_rdata  in  DW  memory read data
o_busy  out  1  high while a transaction is owned (state != IDLE)

Behaviour:
- Reset: i_rst is sampled on the i_clk rising edge. All outputs go to 0, state goes to IDLE, owner is cleared and the latency counter is cleared. Any in-flight transaction is dropped and no rvalid is issued for it.
- Registers: every output is registered except o_busy, which is decoded from state.
- FSM states and transitions:
  - IDLE: if any request is present in cycle N, the winner is latched (owner, we, addr, wdata, wstrb) and the FSM moves to ISSUE.
  - ISSUE (cycle N+1): the owner's gnt=1, o_mem_en=1, and o_mem_we/addr/wdata/wstrb are driven from the latch. Counter is loaded with RD_LAT-1. Next state is WAIT.
  - WAIT: o_mem_en=0. Counter decrements each cycle. When the counter is 0 and the FSM is in WAIT, i_mem_rdata is captured (cycle N+1+RD_LAT) and the FSM moves to RESP.
  - RESP (cycle N+2+RD_LAT): the owner's rvalid=1. rdata is the captured word, or 0 for a write. The FSM returns to IDLE.
- Back-to-back: a request present during RESP is not sampled. Sampling occurs only in IDLE.
- Throughput: one transaction per RD_LAT+3 cycles.
- Latency: request at N gives gnt at N+1 and rvalid at N+2+RD_LAT.
- Arbitration (default, fixed priority): LS beats IF when both requests are high in the sampling cycle.
- Single requester: it wins regardless of priority.
- Requester rules:
  - A requester must hold req and its payload stable until its gnt.
  - Deasserting req before gnt is illegal; behaviour is undefined and not checked.
  - The arbiter ignores payload changes after the IDLE sample.
- Rdata hold: o_if_rdata and o_ls_rdata hold their last value between rvalid pulses. Only the owner's rdata register updates.
- Pulse exclusivity: gnt and rvalid are never high for both requesters in the same cycle.
- Write ack: a write still waits the RD_LAT cycles, which keeps timing uniform. i_mem_rdata is ignored for writes.
- Reset mid-transaction: a reset asserted in ISSUE, WAIT or RESP forces IDLE on the next edge. Pending gnt, rvalid and mem_en are suppressed from that edge.

Optional Feature:
- Macro: NNRV_ARB_RR_EN.
- Defined: round-robin on ties.
  - A last_owner register is updated in ISSUE.
  - On a tie, the requester that was not last_owner wins.
  - last_owner resets to LS, so IF wins the first tie after reset.
  - A lone requester still always wins.
- Undefined: fixed priority with LS first, as described in Behaviour. No last_owner register is built.

Test Plan:
1. Reset, then IF read of addr 0x010 with memory returning 0xDEADBEEF, RD_LAT=1 → o_if_gnt at N+1 with o_mem_en=1, o_mem_addr=0x010; o_if_rvalid at N+3 with o_if_rdata=0xDEADBEEF; o_busy high N+1..N+3.
2. LS write addr 0x020, wdata 0x12345678, wstrb 0xF → o_mem_we=1 with those values during ISSUE; o_ls_rvalid pulse with o_ls_rdata=0; o_if_* stay 0.
3. IF and LS requests both high in the same cycle, held through two transactions:
   - Default: LS granted first, then IF.
   - With NNRV_ARB_RR_EN: IF granted first, then LS, then IF.
4. RD_LAT=4, LS read → rdata captured 5 cycles after the IDLE sample and o_ls_rvalid at N+6; next gnt no earlier than N+8.
5. Reset asserted in the WAIT state → next cycle all outputs 0 and state IDLE; no rvalid for the dropped transaction; a new IF request is granted normally afterward.
6. Streaming IF reads of 0x000..0x007 with continuous req → eight gnts spaced RD_LAT+3 cycles apart; rdata returned in order and matching a memory model.
